// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: control-bus field positions,
// access-size codes, FSM states and the alignment helpers.
package data_mem_responder_pkg;

  localparam int CTRL_W       = 4;
  localparam int CTRL_STORE   = 3;
  localparam int CTRL_UNSIGNED = 2;
  localparam int CTRL_SIZE_HI = 1;
  localparam int CTRL_SIZE_LO = 0;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Drop the low address bits an access of this size cannot use.
  function automatic logic [1:0] natural_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_H:  return {off[1], 1'b0};
      SIZE_W:  return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_H:   return off[0];
      SIZE_W:   return off != 2'b00;
      SIZE_RSV: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the ALU_MEM pipeline register (master) and the
// data memory responder (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic              CSLIn;
  logic [CTRL_W-1:0] dataCacheControlIn;
  logic [31:0]       addrIn;
  logic [31:0]       dataRs2In;
  logic [31:0]       readDataOut;
  logic              readValidOut;
  logic              stallOut;
  logic              errOut;

  modport master (
    output CSLIn, dataCacheControlIn, addrIn, dataRs2In,
    input  readDataOut, readValidOut, stallOut, errOut
  );

  modport slave (
    input  CSLIn, dataCacheControlIn, addrIn, dataRs2In,
    output readDataOut, readValidOut, stallOut, errOut
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated store word,
// plus right-justified sign/zero-extended load data.
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    be      = 4'b0000;
    st_word = '0;
    case (st_size)
      SIZE_B: begin
        be      = 4'b0001 << st_off;
        st_word = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        be      = st_off[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
      end
      SIZE_W: begin
        be      = 4'b1111;
        st_word = st_data;
      end
      default: ;
    endcase
  end

  assign ld_shifted = ld_word >> {ld_off, 3'b000};

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SIZE_B:  ld_data = {{24{~ld_uns & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_H:  ld_data = {{16{~ld_uns & ld_shifted[15]}}, ld_shifted[15:0]};
      SIZE_W:  ld_data = ld_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM with byte/half/word load/store and optional wait states.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned/reserved accesses on errOut.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  localparam int         DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word_q;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [CTRL_W-1:0]   resp_ctrl_q, resp_ctrl_d;
  logic [1:0]          resp_off_q, resp_off_d;

  logic                access_en, wr_en, stall;
  logic [CTRL_W-1:0]   acc_ctrl;
  logic [ADDR_W+1:0]   acc_addr;
  logic [31:0]         acc_wdat;
  logic [1:0]          acc_off;
  logic                acc_err;
  logic [ADDR_W-1:0]   acc_idx;
  logic [3:0]          be;
  logic [31:0]         st_word, ld_data;

  // With no wait states the access uses the live request fields at the accept edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    access_en = 1'b0;
    stall     = 1'b0;
    acc_ctrl  = ctrl_q;
    acc_addr  = addr_q;
    acc_wdat  = wdat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.CSLIn) begin
          ctrl_d   = bus.dataCacheControlIn;
          addr_d   = bus.addrIn[ADDR_W+1:0];
          wdat_d   = bus.dataRs2In;
          acc_ctrl = bus.dataCacheControlIn;
          acc_addr = bus.addrIn[ADDR_W+1:0];
          acc_wdat = bus.dataRs2In;
          if (WS == 4'd0) begin
            access_en = 1'b1;
          end else begin
            cnt_d   = WS;
            state_d = ST_WAIT;
            stall   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          access_en = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    acc_err = is_misaligned(acc_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO], acc_addr[1:0]);
    acc_off = acc_addr[1:0];
`else
    acc_err = 1'b0;
    acc_off = natural_off(acc_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO], acc_addr[1:0]);
`endif
  end

  assign acc_idx = acc_addr[ADDR_W+1:2];
  // A request aborted by reset must never reach the array.
  assign wr_en   = access_en && !rst && acc_ctrl[CTRL_STORE] && !acc_err;

  always_comb begin
    valid_d     = access_en;
    err_d       = access_en && acc_err;
    resp_ctrl_d = access_en ? acc_ctrl : resp_ctrl_q;
    resp_off_d  = access_en ? acc_off  : resp_off_q;
  end

  dmem_lane_align u_align (
    .st_size (acc_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO]),
    .st_off  (acc_off),
    .st_data (acc_wdat),
    .ld_size (resp_ctrl_q[CTRL_SIZE_HI:CTRL_SIZE_LO]),
    .ld_uns  (resp_ctrl_q[CTRL_UNSIGNED]),
    .ld_off  (resp_off_q),
    .ld_word (rd_word_q),
    .be      (be),
    .st_word (st_word),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (access_en) begin
      rd_word_q <= mem[acc_idx];
    end
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[acc_idx][i*8 +: 8] <= st_word[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ctrl_q      <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      resp_ctrl_q <= '0;
      resp_off_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      resp_ctrl_q <= resp_ctrl_d;
      resp_off_q  <= resp_off_d;
    end
  end

  assign bus.readValidOut = valid_q;
  assign bus.errOut       = err_q;
  assign bus.stallOut     = stall;
  assign bus.readDataOut  = (valid_q && !resp_ctrl_q[CTRL_STORE] && !err_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a zero-wait-state instance driven from a vector table and a
// three-wait-state instance exercising stall timing and reset abort.
module tb_data_mem_responder;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  localparam logic [3:0] C_LB  = 4'b0000;
  localparam logic [3:0] C_LH  = 4'b0001;
  localparam logic [3:0] C_LW  = 4'b0010;
  localparam logic [3:0] C_RSV = 4'b0011;
  localparam logic [3:0] C_LBU = 4'b0100;
  localparam logic [3:0] C_LHU = 4'b0101;
  localparam logic [3:0] C_LWU = 4'b0110;
  localparam logic [3:0] C_SB  = 4'b1000;
  localparam logic [3:0] C_SH  = 4'b1001;
  localparam logic [3:0] C_SW  = 4'b1010;
  localparam logic [3:0] C_SRSV = 4'b1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus0();
  data_mem_responder_if bus3();

  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic req0(input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output logic valid,
                      output logic stall);
    @(negedge clk);
    bus0.CSLIn              = 1'b1;
    bus0.dataCacheControlIn = ctrl;
    bus0.addrIn             = addr;
    bus0.dataRs2In          = wdata;
    #1 stall = bus0.stallOut;
    @(posedge clk);
    @(negedge clk);
    valid = bus0.readValidOut;
    rdata = bus0.readDataOut;
    err   = bus0.errOut;
    bus0.CSLIn = 1'b0;
  endtask

  task automatic req3(input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus3.CSLIn              = 1'b1;
    bus3.dataCacheControlIn = ctrl;
    bus3.addrIn             = addr;
    bus3.dataRs2In          = wdata;
    #1 chk("ws3_stall_pre", 32'(bus3.stallOut), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("ws3_stall_t0", 32'(bus3.stallOut), 32'd1);
    chk("ws3_valid_t0", 32'(bus3.readValidOut), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ws3_stall_t1", 32'(bus3.stallOut), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("ws3_stall_t2", 32'(bus3.stallOut), 32'd0);
    chk("ws3_valid_t2", 32'(bus3.readValidOut), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ws3_valid_t3", 32'(bus3.readValidOut), 32'd1);
    rdata = bus3.readDataOut;
    err   = bus3.errOut;
    bus3.CSLIn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ws3_valid_t4", 32'(bus3.readValidOut), 32'd0);
    $display("[ws3] ctrl %b addr %h wdata %h -> data %h err %b", ctrl, addr, wdata, rdata, err);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdata;
    logic        err, valid, stall;
    logic [31:0] w0;

    vecs[0]  = '{C_SW,   32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{C_LB,   32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
    vecs[2]  = '{C_LBU,  32'h13,   32'h0,        32'h000000DE, 1'b0};
    vecs[3]  = '{C_LB,   32'h10,   32'h0,        32'hFFFFFFEF, 1'b0};
    vecs[4]  = '{C_LHU,  32'h10,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[5]  = '{C_LH,   32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
    vecs[6]  = '{C_SW,   32'h20,   32'h11223344, 32'h0,        1'b0};
    vecs[7]  = '{C_SH,   32'h22,   32'hABCD8001, 32'h0,        1'b0};
    vecs[8]  = '{C_LW,   32'h20,   32'h0,        32'h80013344, 1'b0};
    vecs[9]  = '{C_LH,   32'h22,   32'h0,        32'hFFFF8001, 1'b0};
    vecs[10] = '{C_LHU,  32'h22,   32'h0,        32'h00008001, 1'b0};
    vecs[11] = '{C_SB,   32'h21,   32'h123456A5, 32'h0,        1'b0};
    vecs[12] = '{C_LW,   32'h20,   32'h0,        32'h8001A544, 1'b0};
    vecs[13] = '{C_LB,   32'h21,   32'h0,        32'hFFFFFFA5, 1'b0};
    vecs[14] = '{C_SW,   32'h1030, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[15] = '{C_LW,   32'h30,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[16] = '{C_LWU,  32'h30,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[17] = '{C_RSV,  32'h30,   32'h0,        32'h0,        MIS};
    vecs[18] = '{C_SRSV, 32'h30,   32'hFFFFFFFF, 32'h0,        MIS};
    vecs[19] = '{C_LW,   32'h30,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[20] = '{C_SW,   32'h0,    32'h01020304, 32'h0,        1'b0};
    vecs[21] = '{C_SW,   32'h4,    32'h0A0B0C0D, 32'h0,        1'b0};
    vecs[22] = '{C_SW,   32'h2,    32'h12345678, 32'h0,        MIS};
    vecs[23] = '{C_LW,   32'h0,    32'h0,        MIS ? 32'h01020304 : 32'h12345678, 1'b0};
    vecs[24] = '{C_LHU,  32'h11,   32'h0,        MIS ? 32'h0 : 32'h0000BEEF, MIS};
    vecs[25] = '{C_LW,   32'h13,   32'h0,        MIS ? 32'h0 : 32'hDEADBEEF, MIS};

    bus0.CSLIn = 1'b0; bus0.dataCacheControlIn = '0; bus0.addrIn = '0; bus0.dataRs2In = '0;
    bus3.CSLIn = 1'b0; bus3.dataCacheControlIn = '0; bus3.addrIn = '0; bus3.dataRs2In = '0;

    // Reset state on both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", 32'(bus0.readValidOut), 32'd0);
    chk("rst_data0",  bus0.readDataOut,       32'd0);
    chk("rst_err0",   32'(bus0.errOut),       32'd0);
    chk("rst_valid3", 32'(bus3.readValidOut), 32'd0);
    chk("rst_data3",  bus3.readDataOut,       32'd0);
    chk("rst_stall3", 32'(bus3.stallOut),     32'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      req0(vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, rdata, err, valid, stall);
      $display("[ws0] vec %0d ctrl %b addr %h wdata %h -> valid %b data %h err %b",
               i, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, valid, rdata, err);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  rdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i),   32'(err), 32'(vecs[i].exp_err));
    end
    @(negedge clk);
    chk("ws0_pulse_end", 32'(bus0.readValidOut), 32'd0);

    // Back-to-back loads: second request accepted in the cycle the first responds.
    w0 = MIS ? 32'h01020304 : 32'h12345678;
    @(negedge clk);
    bus0.CSLIn = 1'b1; bus0.dataCacheControlIn = C_LW; bus0.addrIn = 32'h0; bus0.dataRs2In = '0;
    #1 chk("b2b_stall_a", 32'(bus0.stallOut), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid_a", 32'(bus0.readValidOut), 32'd1);
    chk("b2b_data_a",  bus0.readDataOut, w0);
    $display("[ws0] b2b load @0 -> data %h", bus0.readDataOut);
    bus0.addrIn = 32'h4;
    #1 chk("b2b_stall_b", 32'(bus0.stallOut), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid_b", 32'(bus0.readValidOut), 32'd1);
    chk("b2b_data_b",  bus0.readDataOut, 32'h0A0B0C0D);
    $display("[ws0] b2b load @4 -> data %h", bus0.readDataOut);
    bus0.CSLIn = 1'b0;

    // Wait-state instance: stall/valid timing for a store and loads.
    req3(C_SW, 32'h8, 32'hA5A5A5A5, rdata, err);
    chk("ws3_store_data", rdata, 32'h0);
    chk("ws3_store_err",  32'(err), 32'd0);
    req3(C_LW, 32'h8, 32'h0, rdata, err);
    chk("ws3_lw_data", rdata, 32'hA5A5A5A5);
    req3(C_LH, 32'h8, 32'h0, rdata, err);
    chk("ws3_lh_data", rdata, 32'hFFFFA5A5);

    // Reset in the middle of a waited store aborts it.
    @(negedge clk);
    bus3.CSLIn = 1'b1; bus3.dataCacheControlIn = C_SW; bus3.addrIn = 32'h8; bus3.dataRs2In = 32'h55;
    @(posedge clk);
    @(negedge clk);
    chk("abort_stall_wait", 32'(bus3.stallOut), 32'd1);
    rst = 1'b1;
    bus3.CSLIn = 1'b0;
    #1;
    chk("abort_stall", 32'(bus3.stallOut),     32'd0);
    chk("abort_valid", 32'(bus3.readValidOut), 32'd0);
    chk("abort_data",  bus3.readDataOut,       32'd0);
    chk("abort_err",   32'(bus3.errOut),       32'd0);
    $display("[ws3] store 0x55 @8 aborted by reset");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req3(C_LW, 32'h8, 32'h0, rdata, err);
    chk("abort_mem_kept", rdata, 32'hA5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the ALU_MEM-to-RAM data path. It accepts registered load/store requests (chip select, control bus, address, store data) from the ALU/MEM pipeline register and performs byte/half/word accesses on an internal word-organised data RAM. It returns sign- or zero-extended load data toward MEM_WB and stalls the pipeline during configurable wait states.

Parameters:
ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words
WAIT_STATES, 0, extra cycles before the access edge (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
CSLIn  input  1  request strobe from ALU_MEM (CSLToDataCacheOut)
dataCacheControlIn  input  4  [3]=store, [2]=unsigned load, [1:0] size 00=byte 01=half 10=word 11=reserved
addrIn  input  32  byte address (ALU result, dataOut)
dataRs2In  input  32  store data (dataRs2Out)
readDataOut  output  32  extended load data, valid while readValidOut=1
readValidOut  output  1  one-cycle pulse per completed request, load or store
stallOut  output  1  upstream must hold its registers while high
errOut  output  1  misalignment/reserved-size flag, coincident with readValidOut (feature only)

Behaviour:
- Reset: state IDLE, wait counter 0, readDataOut=0, readValidOut=0, errOut=0. RAM contents are not cleared. Reset during WAIT aborts the request; a pending store never writes.
- FSM states: IDLE and WAIT.
- IDLE, CSLIn=1: request is accepted at the edge and fields are latched.
  - WAIT_STATES=0: access is performed at that same edge, state stays IDLE.
  - Otherwise: counter loads WAIT_STATES and state goes to WAIT.
- WAIT: counter decrements every edge. At the edge where the counter equals 1, the access is performed from the latched fields and state returns to IDLE.
- Latency: readValidOut is high for exactly one cycle, in the cycle after the access edge, i.e. WAIT_STATES+1 cycles after acceptance.
- Back-to-back: a new CSLIn in the cycle readValidOut is high is accepted normally.
- stallOut (combinational): (IDLE && CSLIn && WAIT_STATES!=0) || (WAIT && counter>1). It is low in the cycle of the access edge, so upstream advances on that edge.
- CSLIn is ignored in WAIT; upstream holds it stable because stallOut is high.
- Word index = addr[ADDR_W+1:2]. Higher address bits are discarded, so addresses wrap modulo RAM size.
- Store lanes:
  - byte: lane addr[1:0] written with rs2[7:0]
  - half: lanes {addr[1],0} and {addr[1],1} written with rs2[15:0]
  - word: all lanes written with rs2
  - Non-selected lanes are unchanged. readDataOut=0 for stores.
- Load: the selected byte/half is right-justified, then zero-extended if the unsigned bit is set, otherwise sign-extended. Word loads ignore the unsigned bit.
- Reserved size 11: no RAM write, readDataOut=0, readValidOut still pulses.
- Read-during-write conflicts cannot occur: exactly one access per request.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: a half access with addr[0]=1, a word access with addr[1:0]!=0, or a reserved size is flagged. The store is suppressed, readDataOut=0, and errOut=1 alongside readValidOut.
- Undefined: errOut is tied 0. Address low bits are forced to natural alignment (half ignores addr[0], word ignores addr[1:0]) and the access proceeds.

Decomposition:
- define.v gains DataCacheControlBus field indices, size codes (SIZE_B/H/W/RSV) and the store/unsigned bit positions.
- One natural sub-module: dmem_lane_align. It is combinational and produces the byte-enable mask, the shifted store word and the extended load data from size, unsigned and addr[1:0]. It is reused by a future data cache.
- The FSM and RAM array stay in the top module.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF @0x10, then signed-byte load @0x13 -> readValidOut one cycle after accept, data 0xFFFFFFDE; unsigned byte @0x13 -> 0x000000DE.
- Half store 0x8001 @0x22 over word 0x11223344 @0x20 -> word reads 0x80013344; signed half load @0x22 -> 0xFFFF8001.
- WAIT_STATES=3: load accepted at edge T -> stallOut high during T-1 (with CSLIn), T and T+1, low in T+2; access at edge T+3; readValidOut high in cycle T+3..T+4 only.
- Back-to-back loads @0x0 and @0x4 with WAIT_STATES=0 -> two consecutive readValidOut pulses with the correct data each, no stall.
- Assert rst during WAIT of a store 0x55 @0x8 -> outputs zero immediately; word @0x8 unchanged afterwards.
- With DMEM_MISALIGN_CHECK_EN: word store @0x2 -> errOut=1 with readValidOut, RAM unchanged; without the macro the same store writes word index 0.
